// File: rtl/fx3_pkg.sv
// Shared definitions for the FX3 slave-FIFO transmit path: FSM encodings,
// socket addresses and default packet/guard sizing.
package fx3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_PKTEND = 2'd2,
        ST_GUARD  = 2'd3
    } fx3_state_e;

    localparam logic [1:0] FX3_SOCKET_0 = 2'b00;
    localparam logic [1:0] FX3_SOCKET_1 = 2'b01;
    localparam logic [1:0] FX3_SOCKET_2 = 2'b10;
    localparam logic [1:0] FX3_SOCKET_3 = 2'b11;

    localparam int FX3_DEF_BURST_LEN    = 256;
    localparam int FX3_DEF_GUARD_CYCLES = 3;

endpackage

// File: rtl/fx3_slfifo_tx.sv
// AXI-Stream to Cypress FX3 synchronous slave-FIFO writer. Full packets end on
// the word count alone; short packets are closed with a single PKTEND strobe.
module fx3_slfifo_tx
    import fx3_pkg::*;
#(
    parameter int         DATA_WIDTH   = 32,
    parameter int         BURST_LEN    = FX3_DEF_BURST_LEN,
    parameter int         GUARD_CYCLES = FX3_DEF_GUARD_CYCLES,
    parameter logic [1:0] SOCKET_ADDR  = FX3_SOCKET_0
) (
    input  logic                    s_aclk,
    input  logic                    s_aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    fx3_flaga,
    output logic [DATA_WIDTH-1:0]   fx3_data,
    output logic                    fx3_slwr_n,
    output logic                    fx3_pktend_n,
    output logic                    fx3_slcs_n,
    output logic [1:0]              fx3_addr,
    output logic [15:0]             tx_pkt_cnt,
    output logic                    keep_err
);

    localparam int CNT_W  = $clog2(BURST_LEN) + 1;
    localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [GCNT_W-1:0] GUARD_LAST  = GCNT_W'(GUARD_CYCLES - 1);

    fx3_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [GCNT_W-1:0]     gcnt_q, gcnt_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic                  keep_err_q, keep_err_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  slwr_n_q, slwr_n_d;
    logic                  pktend_n_q, pktend_n_d;
    logic                  slcs_n_q;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gcnt_d        = gcnt_q;
        pkt_cnt_d     = pkt_cnt_q;
        keep_err_d    = keep_err_q;
        data_d        = data_q;
        slwr_n_d      = 1'b1;
        pktend_n_d    = 1'b1;
        s_axis_tready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // flaga is only looked at here; a drop mid-burst is ignored.
                if (fx3_flaga && s_axis_tvalid) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    data_d   = s_axis_tdata;
                    slwr_n_d = 1'b0;
                    cnt_d    = cnt_inc;
                    if (!s_axis_tlast && (s_axis_tkeep != '1))
                        keep_err_d = 1'b1;
                    // A full packet commits on its own; tlast on the final word needs no PKTEND.
                    if (cnt_inc == BURST_LEN_C) begin
                        state_d   = ST_GUARD;
                        gcnt_d    = '0;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else if (s_axis_tlast) begin
                        state_d = ST_PKTEND;
                    end
                end
            end
            ST_PKTEND: begin
                pktend_n_d = 1'b0;
                state_d    = ST_GUARD;
                gcnt_d     = '0;
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
            end
            ST_GUARD: begin
                if (gcnt_q == GUARD_LAST)
                    state_d = ST_IDLE;
                else
                    gcnt_d = gcnt_q + GCNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            pkt_cnt_q  <= '0;
            keep_err_q <= 1'b0;
            data_q     <= '0;
            slwr_n_q   <= 1'b1;
            pktend_n_q <= 1'b1;
            slcs_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            keep_err_q <= keep_err_d;
            data_q     <= data_d;
            slwr_n_q   <= slwr_n_d;
            pktend_n_q <= pktend_n_d;
            slcs_n_q   <= 1'b0;
        end
    end

    assign fx3_data     = data_q;
    assign fx3_slwr_n   = slwr_n_q;
    assign fx3_pktend_n = pktend_n_q;
    assign fx3_slcs_n   = slcs_n_q;
    assign fx3_addr     = SOCKET_ADDR;
    assign tx_pkt_cnt   = pkt_cnt_q;
    assign keep_err     = keep_err_q;

endmodule

// File: tb/tb_fx3_slfifo_tx.sv
// Directed bench for fx3_slfifo_tx: a cycle-by-cycle vector table followed by
// packet-level sequences checked against a queue of expected FX3 writes.
module tb_fx3_slfifo_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tvalid, tready, flaga;
    logic [31:0] fx3_data;
    logic        slwr_n, pktend_n, slcs_n;
    logic [1:0]  addr;
    logic [15:0] pkt_cnt;
    logic        kerr;

    always #5 clk = ~clk;

    fx3_slfifo_tx #(
        .DATA_WIDTH(32), .BURST_LEN(256), .GUARD_CYCLES(3), .SOCKET_ADDR(2'b00)
    ) dut (
        .s_aclk(clk), .s_aresetn(rstn),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .fx3_flaga(flaga), .fx3_data(fx3_data), .fx3_slwr_n(slwr_n),
        .fx3_pktend_n(pktend_n), .fx3_slcs_n(slcs_n), .fx3_addr(addr),
        .tx_pkt_cnt(pkt_cnt), .keep_err(kerr)
    );

    typedef struct {
        logic        rstn, flaga, tvalid, tlast;
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic        e_tready, e_slwr_n, e_pktend_n, e_slcs_n, e_keep_err;
        logic [31:0] e_data;
        logic [15:0] e_pkt;
    } vec_t;

    vec_t        vec [15];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] act_q [$];
    int          pe_cnt = 0;
    int          overlap = 0;

    // Bus monitor: records every FX3 write and PKTEND strobe.
    always @(negedge clk) begin
        if (!slwr_n) act_q.push_back(fx3_data);
        if (!pktend_n) pe_cnt++;
        if (!slwr_n && !pktend_n) overlap++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rstn = 1'b0; tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF; flaga = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drives one packet; returns at the negedge just before the last handshake edge
    // (or at the negedge where beat abort_at would have been driven).
    task automatic send(input string nm, input int n, input logic [31:0] base,
                        input bit gapped, input bit drop_flaga, input int bad_beat,
                        input logic [3:0] last_keep, input int abort_at);
        int beat = 0;
        int cyc  = 0;
        bit tog  = 1'b1;
        while (beat < n && cyc < 5000) begin
            @(negedge clk);
            if (abort_at >= 0 && beat == abort_at) break;
            if (drop_flaga && beat > 0) flaga = 1'b0;
            tvalid = gapped ? tog : 1'b1;
            tog    = ~tog;
            tdata  = base + 32'(beat);
            tlast  = (beat == n - 1);
            tkeep  = (beat == bad_beat) ? 4'h7 : ((beat == n - 1) ? last_keep : 4'hF);
            #1;
            if (tvalid && tready) begin
                exp_q.push_back(tdata);
                beat++;
            end
            cyc++;
        end
        if (abort_at < 0) chk({nm, "_beats"}, 32'(beat), 32'(n));
    endtask

    task automatic meas_gap(output int gap);
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tvalid = 1'b1; tlast = 1'b0; tkeep = 4'hF; tdata = 32'hDEAD_0000;
            #1;
            if (tready) break;
            gap++;
        end
        tvalid = 1'b0;
    endtask

    task automatic idle_out(input int n);
        @(negedge clk);
        tvalid = 1'b0; flaga = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_pkt(input string nm, input int a0, input int p0,
                             input int exp_pe, input logic [15:0] exp_pc);
        int bad = 0;
        chk({nm, "_nwrites"}, 32'(act_q.size() - a0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (a0 + i >= act_q.size() || act_q[a0 + i] !== exp_q[i]) bad++;
        chk({nm, "_data_order_bad"}, 32'(bad), 32'd0);
        chk({nm, "_pktend"}, 32'(pe_cnt - p0), 32'(exp_pe));
        chk({nm, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pc));
        chk({nm, "_overlap"}, 32'(overlap), 32'd0);
    endtask

    initial begin
        int a0, p0, gap, bad;

        //          rst fa tv tl data           keep  rdy wr pe cs ke data           pkt
        vec[0]  = '{0, 1, 1, 0, 32'hA1,        4'hF, 0, 1, 1, 1, 0, 32'h0,         16'd0};
        vec[1]  = '{1, 0, 1, 0, 32'h11,        4'hF, 0, 1, 1, 1, 0, 32'h0,         16'd0};
        vec[2]  = '{1, 1, 1, 0, 32'h11,        4'hF, 0, 1, 1, 0, 0, 32'h0,         16'd0};
        vec[3]  = '{1, 1, 1, 0, 32'h11,        4'hF, 1, 1, 1, 0, 0, 32'h0,         16'd0};
        vec[4]  = '{1, 1, 0, 0, 32'h22,        4'hF, 1, 0, 1, 0, 0, 32'h11,        16'd0};
        vec[5]  = '{1, 1, 1, 0, 32'h22,        4'h7, 1, 1, 1, 0, 0, 32'h11,        16'd0};
        vec[6]  = '{1, 1, 1, 1, 32'h33,        4'h7, 1, 0, 1, 0, 1, 32'h22,        16'd0};
        vec[7]  = '{1, 1, 1, 0, 32'h44,        4'hF, 0, 0, 1, 0, 1, 32'h33,        16'd0};
        vec[8]  = '{1, 1, 1, 0, 32'h44,        4'hF, 0, 1, 0, 0, 1, 32'h33,        16'd1};
        vec[9]  = '{1, 1, 1, 0, 32'h44,        4'hF, 0, 1, 1, 0, 1, 32'h33,        16'd1};
        vec[10] = '{1, 1, 1, 0, 32'h44,        4'hF, 0, 1, 1, 0, 1, 32'h33,        16'd1};
        vec[11] = '{1, 1, 1, 0, 32'h44,        4'hF, 0, 1, 1, 0, 1, 32'h33,        16'd1};
        vec[12] = '{1, 1, 0, 0, 32'h44,        4'hF, 1, 1, 1, 0, 1, 32'h33,        16'd1};
        vec[13] = '{0, 1, 1, 0, 32'h55,        4'hF, 1, 1, 1, 0, 1, 32'h33,        16'd1};
        vec[14] = '{1, 0, 0, 0, 32'h66,        4'hF, 0, 1, 1, 1, 0, 32'h0,         16'd0};

        rstn = 1'b0; flaga = 1'b0; tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF; tdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rstn = vec[i].rstn; flaga = vec[i].flaga; tvalid = vec[i].tvalid;
            tlast = vec[i].tlast; tdata = vec[i].tdata; tkeep = vec[i].tkeep;
            #1;
            chk($sformatf("v%0d_tready", i),   32'(tready),   32'(vec[i].e_tready));
            chk($sformatf("v%0d_slwr_n", i),   32'(slwr_n),   32'(vec[i].e_slwr_n));
            chk($sformatf("v%0d_pktend_n", i), 32'(pktend_n), 32'(vec[i].e_pktend_n));
            chk($sformatf("v%0d_slcs_n", i),   32'(slcs_n),   32'(vec[i].e_slcs_n));
            chk($sformatf("v%0d_keep_err", i), 32'(kerr),     32'(vec[i].e_keep_err));
            chk($sformatf("v%0d_data", i),     fx3_data,      vec[i].e_data);
            chk($sformatf("v%0d_pkt_cnt", i),  32'(pkt_cnt),  32'(vec[i].e_pkt));
            chk($sformatf("v%0d_addr", i),     32'(addr),     32'd0);
        end

        // Full 256-word packet: no PKTEND, GUARD then IDLE before the next burst.
        do_rst(); exp_q.delete(); a0 = act_q.size(); p0 = pe_cnt;
        send("full", 256, 32'h1000_0000, 1'b0, 1'b0, -1, 4'hF, -1);
        meas_gap(gap);
        chk("full_guard_gap", 32'(gap), 32'd4);
        idle_out(3);
        check_pkt("full", a0, p0, 0, 16'd1);

        // Short 10-word packet closed by PKTEND.
        do_rst(); exp_q.delete(); a0 = act_q.size(); p0 = pe_cnt;
        send("short", 10, 32'h2000_0000, 1'b0, 1'b0, -1, 4'hF, -1);
        meas_gap(gap);
        chk("short_gap", 32'(gap), 32'd5);
        idle_out(3);
        check_pkt("short", a0, p0, 1, 16'd1);

        // Gapped 256-word packet; flaga drops after the first beat and must be ignored.
        do_rst(); exp_q.delete(); a0 = act_q.size(); p0 = pe_cnt;
        send("gapped", 256, 32'h3000_0000, 1'b1, 1'b1, -1, 4'hF, -1);
        idle_out(8);
        check_pkt("gapped", a0, p0, 0, 16'd1);

        // Back-pressure from flaga while data is waiting.
        do_rst();
        flaga = 1'b0; tvalid = 1'b1; tlast = 1'b0; bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (tready || !slwr_n) bad++;
        end
        chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
        @(negedge clk); flaga = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_tready", 32'(tready), 32'd1);
        tvalid = 1'b0;

        // Reset at beat 100, then a normal 5-word packet.
        do_rst(); exp_q.delete(); a0 = act_q.size(); p0 = pe_cnt;
        send("abort", 256, 32'h4000_0000, 1'b0, 1'b0, -1, 4'hF, 100);
        rstn = 1'b0; tvalid = 1'b0;
        @(negedge clk); #1;
        chk("abort_tready", 32'(tready), 32'd0);
        chk("abort_slwr_n", 32'(slwr_n), 32'd1);
        chk("abort_pktend_n", 32'(pktend_n), 32'd1);
        chk("abort_data", fx3_data, 32'd0);
        chk("abort_slcs_n", 32'(slcs_n), 32'd1);
        rstn = 1'b1;
        idle_out(5);
        check_pkt("abort", a0, p0, 0, 16'd0);
        exp_q.delete(); a0 = act_q.size(); p0 = pe_cnt;
        send("post_abort", 5, 32'h5000_0000, 1'b0, 1'b0, -1, 4'hF, -1);
        idle_out(8);
        check_pkt("post_abort", a0, p0, 1, 16'd1);

        // Packet counter wrap and sticky keep error.
        do_rst();
        force dut.pkt_cnt_q = 16'hFFFF;
        @(negedge clk); @(negedge clk);
        release dut.pkt_cnt_q;
        #1;
        chk("wrap_preset", 32'(pkt_cnt), 32'h0000_FFFF);
        send("wrap", 3, 32'h6000_0000, 1'b0, 1'b0, -1, 4'h1, -1);
        idle_out(8);
        chk("wrap_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("last_partial_keep_ok", 32'(kerr), 32'd0);
        send("kerr", 4, 32'h7000_0000, 1'b0, 1'b0, 1, 4'hF, -1);
        idle_out(8);
        chk("kerr_set", 32'(kerr), 32'd1);
        chk("kerr_pkt_cnt", 32'(pkt_cnt), 32'd1);
        send("kerr_clean", 2, 32'h8000_0000, 1'b0, 1'b0, -1, 4'hF, -1);
        idle_out(8);
        chk("kerr_sticky", 32'(kerr), 32'd1);
        do_rst(); #1;
        chk("kerr_reset", 32'(kerr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fx3_slfifo_tx.md
FX3_SLFIFO_TX -- requirements
Module: fx3_slfifo_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the AXIS tdata and FX3 data bus.
REQ-002 SHALL have parameter BURST_LEN, default 256: words per full USB packet (1024 B at 32 bit).
REQ-003 SHALL have parameter GUARD_CYCLES, default 3: idle cycles after each packet for FX3 flag update.
REQ-004 SHALL have parameter SOCKET_ADDR, default 2'b00: FX3 socket address driven on fx3_addr.
REQ-005 SHALL use one clock and a synchronous, active-low reset: s_aclk input 1 is the clock; s_aresetn input 1 is the synchronous active-low reset.
REQ-006 SHALL have the AXIS ports: s_axis_tdata input DATA_WIDTH, s_axis_tkeep input DATA_WIDTH/8, s_axis_tlast input 1, s_axis_tvalid input 1, s_axis_tready output 1.
REQ-007 SHALL have fx3_flaga input 1: FX3 DMA buffer ready, active high.
REQ-008 SHALL have the FX3 outputs: fx3_data output DATA_WIDTH, fx3_slwr_n output 1, fx3_pktend_n output 1, fx3_slcs_n output 1, fx3_addr output 2.
REQ-009 SHALL have the status outputs: tx_pkt_cnt output 16 (committed packets), keep_err output 1 (sticky).

Function
REQ-010 SHALL implement states IDLE, BURST, PKTEND and GUARD.
REQ-011 IDLE -> BURST SHALL occur when fx3_flaga=1 and s_axis_tvalid=1; tready SHALL be 0 in IDLE.
REQ-012 In BURST, s_axis_tready SHALL be 1 combinationally; each handshake SHALL register tdata onto fx3_data with fx3_slwr_n=0 on the next cycle (latency 1).
REQ-013 The word counter (log2(BURST_LEN)+1 bits) SHALL clear on entry to BURST and increment per handshake.
REQ-014 On a handshake with counter+1==BURST_LEN, the block SHALL go to GUARD without pktend, whether or not tlast=1.
REQ-015 On a handshake with tlast=1 and counter+1<BURST_LEN, the block SHALL go to PKTEND.
REQ-016 PKTEND SHALL drive fx3_pktend_n=0 with fx3_slwr_n=1 for exactly one cycle, then go to GUARD.
REQ-017 GUARD SHALL hold tready=0 and slwr_n=1 for GUARD_CYCLES cycles, then return to IDLE.
REQ-018 tvalid=0 in BURST SHALL insert a wait cycle (slwr_n=1); the block SHALL stay in BURST and the counter SHALL be held.
REQ-019 tx_pkt_cnt SHALL increment by 1 on entry to GUARD and SHALL wrap from 0xFFFF to 0.
REQ-020 keep_err SHALL set when a handshake has tlast=0 and tkeep is not all ones; it SHALL clear only on reset; the data SHALL still be written.
REQ-021 fx3_addr SHALL equal SOCKET_ADDR constantly.
REQ-022 fx3_slcs_n SHALL be 0 whenever the block is out of reset.
REQ-023 fx3_flaga deasserting mid-BURST SHALL be ignored; it SHALL be sampled only in IDLE.

Reset
REQ-024 While s_aresetn=0 at a rising edge, the following SHALL apply on the next cycle: state=IDLE, counter=0, tx_pkt_cnt=0, keep_err=0, s_axis_tready=0, fx3_data=0, fx3_slwr_n=1, fx3_pktend_n=1, fx3_slcs_n=1.
REQ-025 A reset in mid-BURST SHALL abandon the packet with no pktend; no further slwr_n pulse SHALL occur.

Structure
REQ-026 Shared package fx3_pkg SHALL hold the state encodings, FX3 socket address constants and the default BURST_LEN/GUARD_CYCLES.
REQ-027 The block SHALL contain no sub-modules; the counters and FSM SHALL be inline.
REQ-028 The block SHALL be fed by the existing AXIS data FIFO in common_clock mode.

Verification
REQ-029 Full packet: flaga=1, 256 continuous beats, tlast on beat 256 -> 256 slwr_n pulses with matching data, no pktend, tx_pkt_cnt=1, 3 GUARD cycles.
REQ-030 Short packet: 10 beats, tlast on beat 10 -> 10 slwr_n pulses, then one pktend_n=0 cycle with slwr_n=1, tx_pkt_cnt=1.
REQ-031 Gapped: 256 beats with tvalid toggling every other cycle -> exactly 256 writes, data in order, no pktend.
REQ-032 Back-pressure: flaga=0 with tvalid=1 for 50 cycles -> tready=0 and slwr_n=1 throughout; flaga=1 -> BURST within 1 cycle.
REQ-033 Reset at beat 100 of 256 -> all outputs at reset values next cycle, no pktend; the following 5-beat packet is handled normally.
REQ-034 Wrap/error: force tx_pkt_cnt=0xFFFF, then send 1 packet -> 0x0000; tkeep=4'b0111 on a non-last beat -> keep_err=1 and sticky until reset.
